alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_fifo.sv | 86 ++++++++
 rtl/alu_pipe.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode enum and result-entry flag struct for the ALU pipe
package alu_pkg;

    // Opcodes 0..10; encodings 11..15 are illegal and flagged through err.
    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_XOR    = 4'd2,
        OP_AND    = 4'd3,
        OP_OR     = 4'd4,
        OP_XNOR   = 4'd5,
        OP_NAND   = 4'd6,
        OP_DECA   = 4'd7,
        OP_INCB2  = 4'd8,
        OP_ACC    = 4'd9,
        OP_CLRACC = 4'd10
    } op_e;

    // Status half of a result entry. The result value C sits above these
    // bits in the FIFO word, because its width follows OUT_WIDTH.
    typedef struct packed {
        logic ovf;
        logic zero;
        logic err;
    } res_flags_t;

    localparam int FLAG_W = $bits(res_flags_t);

endpackage

// File: rtl/alu_fifo.sv
// rtl/alu_fifo.sv - circular result buffer between the ALU stage and the output
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (clears pointers and count)
//   push, din   write din at the tail (ignored when full)
//   pop         drop the head (ignored when empty)
//   dout        current head entry
//   count       number of stored entries
//   full, empty occupancy status
module alu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        // Simultaneous push and pop leaves the count alone.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage signed ALU with accumulator and buffered results
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ALU_en              enables new accepts; queued work drains regardless
//   in_valid, in_ready  request handshake
//   op, sat_en, A, B    opcode, saturation enable, signed operands
//   out_valid, out_ready result handshake on the FIFO head
//   C, ovf, zero, err   head result and flags (all 0 when out_valid=0)
module alu_pipe #(
    parameter int DATA_WIDTH = 5,
    parameter int OUT_WIDTH  = DATA_WIDTH + 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ALU_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op,
    input  logic                  sat_en,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  C,
    output logic                  ovf,
    output logic                  zero,
    output logic                  err
);

    import alu_pkg::*;

    localparam int DW    = DATA_WIDTH;
    localparam int OW    = OUT_WIDTH;
    localparam int EW    = OW + FLAG_W;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Clamp limits: D_* for DATA_WIDTH-range ops, O_* for the accumulator.
    localparam logic signed [OW-1:0] D_MAX = {{(OW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [OW-1:0] D_MIN = {{(OW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [OW-1:0] O_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0] O_MIN = {1'b1, {(OW-1){1'b0}}};
    localparam logic signed [OW-1:0] ONE   = OW'(1);
    localparam logic signed [OW-1:0] TWO   = OW'(2);
    localparam logic [CNT_W:0]       DEPTH_OCC = (CNT_W+1)'(DEPTH);

    // Stage 1 registers
    logic                 s1_valid_q, s1_valid_d;
    logic [3:0]           s1_op_q, s1_op_d;
    logic                 s1_sat_q, s1_sat_d;
    logic signed [DW-1:0] s1_a_q, s1_a_d;
    logic signed [DW-1:0] s1_b_q, s1_b_d;
    logic signed [OW-1:0] acc_q, acc_d;

    // Datapath
    logic signed [OW-1:0] a_ext, b_ext;
    logic signed [OW-1:0] exact;
    logic signed [OW:0]   acc_sum;
    logic [DW-1:0]        logic_r;
    logic                 is_arith;
    logic                 is_logic;
    logic signed [OW-1:0] res_c;
    res_flags_t           res_flags;

    // FIFO side
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [EW-1:0]        fifo_dout;
    logic [CNT_W:0]       occupancy;
    logic                 accept;
    logic [OW-1:0]        head_c;
    res_flags_t           head_flags;

    // Entries already in the FIFO plus the one in stage 1 must leave room;
    // a pop in the same cycle is deliberately not credited.
    assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(s1_valid_q);
    assign in_ready  = rst_n && ALU_en && !fifo_full && (occupancy < DEPTH_OCC);
    assign accept    = in_valid && in_ready;

    always_comb begin
        s1_valid_d = accept;
        s1_op_d    = s1_op_q;
        s1_sat_d   = s1_sat_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (accept) begin
            s1_op_d  = op;
            s1_sat_d = sat_en;
            s1_a_d   = A;
            s1_b_d   = B;
        end
    end

    assign a_ext = {{(OW-DW){s1_a_q[DW-1]}}, s1_a_q};
    assign b_ext = {{(OW-DW){s1_b_q[DW-1]}}, s1_b_q};

    always_comb begin
        exact     = '0;
        acc_sum   = '0;
        logic_r   = '0;
        is_arith  = 1'b0;
        is_logic  = 1'b0;
        res_c     = '0;
        res_flags = '0;
        acc_d     = acc_q;

        case (s1_op_q)
            OP_ADD:   begin exact = a_ext + b_ext; is_arith = 1'b1; end
            OP_SUB:   begin exact = a_ext - b_ext; is_arith = 1'b1; end
            OP_DECA:  begin exact = a_ext - ONE;   is_arith = 1'b1; end
            OP_INCB2: begin exact = b_ext + TWO;   is_arith = 1'b1; end
            OP_XOR:   begin logic_r = s1_a_q ^ s1_b_q;    is_logic = 1'b1; end
            OP_AND:   begin logic_r = s1_a_q & s1_b_q;    is_logic = 1'b1; end
            OP_OR:    begin logic_r = s1_a_q | s1_b_q;    is_logic = 1'b1; end
            OP_XNOR:  begin logic_r = ~(s1_a_q ^ s1_b_q); is_logic = 1'b1; end
            OP_NAND:  begin logic_r = ~(s1_a_q & s1_b_q); is_logic = 1'b1; end
            OP_ACC: begin
                // One extra bit catches the OUT_WIDTH overflow: the top two
                // bits of the sum disagree exactly when it is out of range.
                acc_sum       = {acc_q[OW-1], acc_q} + {a_ext[OW-1], a_ext};
                res_flags.ovf = acc_sum[OW] ^ acc_sum[OW-1];
                if (res_flags.ovf && s1_sat_q) begin
                    res_c = acc_sum[OW] ? O_MIN : O_MAX;
                end else begin
                    res_c = acc_sum[OW-1:0];
                end
                acc_d = res_c;
            end
            OP_CLRACC: acc_d = '0;
            default:   res_flags.err = 1'b1;
        endcase

        if (is_logic) begin
            res_c = {{(OW-DW){logic_r[DW-1]}}, logic_r};
        end

        // OUT_WIDTH >= DATA_WIDTH+1 holds these results exactly, so the
        // range test is a plain signed compare against the DATA_WIDTH limits.
        if (is_arith) begin
            res_c = exact;
            if (exact > D_MAX) begin
                res_flags.ovf = 1'b1;
                if (s1_sat_q) res_c = D_MAX;
            end else if (exact < D_MIN) begin
                res_flags.ovf = 1'b1;
                if (s1_sat_q) res_c = D_MIN;
            end
        end

        res_flags.zero = (res_c == '0);

        // The accumulator only moves when its op actually leaves stage 1.
        if (!s1_valid_q) begin
            acc_d = acc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_sat_q   <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_sat_q   <= s1_sat_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            acc_q      <= acc_d;
        end
    end

    // Stage 1 always empties into the FIFO: in_ready guaranteed the slot.
    alu_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s1_valid_q),
        .pop   (out_ready),
        .din   ({res_c, res_flags}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_c     = fifo_dout[EW-1:FLAG_W];
    assign head_flags = fifo_dout[FLAG_W-1:0];
    assign out_valid  = !fifo_empty;
    assign C          = out_valid ? head_c : '0;
    assign ovf        = out_valid && head_flags.ovf;
    assign zero       = out_valid && head_flags.zero;
    assign err        = out_valid && head_flags.err;

endmodule
